button_debouncer: RTL

// - Input conditioning stage for mechanical switches and buttons. It sits directly upstream of the edge detector.
// - Synchronises the asynchronous btn_in into the clk domain and rejects bounce/glitches shorter than DEBOUNCE_CYCLES.
// - Its btn_level output is the clean, single-domain level that drives the edge detector D input.
// - Also counts rejected glitches so that contact quality is observable.
//

---
 rtl/debounce_pkg.sv | 21 ++
 rtl/button_debouncer_sync_chain.sv | 25 ++
 rtl/button_debouncer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and parameter limits for the button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } db_state_t;

  localparam int unsigned MIN_SYNC_STAGES     = 2;
  localparam int unsigned MIN_DEBOUNCE_CYCLES = 2;

  // True when the chosen sizing can actually synchronise and qualify a level.
  function automatic bit params_ok(input int unsigned sync_stages,
                                   input int unsigned debounce_cycles);
    return (sync_stages >= MIN_SYNC_STAGES) &&
           (debounce_cycles >= MIN_DEBOUNCE_CYCLES);
  endfunction

endpackage

// File: rtl/button_debouncer_sync_chain.sv
// N-flop synchroniser for an asynchronous single-bit input, reset to a chosen level.
module sync_chain #(
  parameter int unsigned STAGES      = 2,
  parameter bit          RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic data,
  output logic synced
);

  logic [STAGES-1:0] q;

  // Shift the raw input through the chain; the last flop is the clean sample.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= {STAGES{RESET_LEVEL}};
    end else begin
      q <= {q[STAGES-2:0], data};
    end
  end

  assign synced = q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces a mechanical switch: synchronise, qualify stable levels, count rejected glitches.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned GLITCH_W        = 8,
  parameter bit          RESET_LEVEL     = 1'b0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                btn_in,
  input  logic                glitch_clr,
  output logic                btn_level,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int unsigned         CNT_W      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  if (!params_ok(SYNC_STAGES, DEBOUNCE_CYCLES)) begin : g_param_err
    $error("button_debouncer: SYNC_STAGES and DEBOUNCE_CYCLES must both be >= 2");
  end

  db_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             s;
  logic             glitch_ev_c;

  sync_chain #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .data   (btn_in),
    .synced (s)
  );

  // A pending change is abandoned when the sample falls back to the old level.
  always_comb begin
    glitch_ev_c = 1'b0;
    if ((state == PEND_HI && !s) || (state == PEND_LO && s)) begin
      glitch_ev_c = 1'b1;
    end
  end

  // Qualification FSM; btn_level and busy are registered alongside the state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= RESET_LEVEL ? STABLE_HI : STABLE_LO;
      cnt       <= '0;
      btn_level <= RESET_LEVEL;
      busy      <= 1'b0;
    end else begin
      case (state)
        STABLE_LO: begin
          if (s) begin
            state <= PEND_HI;
            cnt   <= CNT_W'(1);
            busy  <= 1'b1;
          end
        end
        PEND_HI: begin
          if (!s) begin
            state <= STABLE_LO;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state     <= STABLE_HI;
            btn_level <= 1'b1;
            cnt       <= '0;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!s) begin
            state <= PEND_LO;
            cnt   <= CNT_W'(1);
            busy  <= 1'b1;
          end
        end
        PEND_LO: begin
          if (s) begin
            state <= STABLE_HI;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state     <= STABLE_LO;
            btn_level <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= STABLE_LO;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating glitch counter; a clear request beats a same-cycle glitch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      glitch_cnt <= '0;
    end else if (glitch_clr) begin
      glitch_cnt <= '0;
    end else if (glitch_ev_c && (glitch_cnt != GLITCH_MAX)) begin
      glitch_cnt <= glitch_cnt + GLITCH_W'(1);
    end
  end

endmodule
